// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// pipeline-depth helpers used by shift_pipe and shift_stage.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_OP_SLL = 2'b00,
    SH_OP_SRL = 2'b01,
    SH_OP_SRA = 2'b10,
    SH_OP_ROR = 2'b11
  } sh_op_e;

  // Number of register groups needed to cover all mux stages.
  function automatic int unsigned calc_lat(input int unsigned shamt_w,
                                           input int unsigned stages_per_reg);
    return (shamt_w + stages_per_reg - 1) / stages_per_reg;
  endfunction

  // Index of the last mux stage that belongs to register group g.
  function automatic int unsigned group_last_stage(input int unsigned g,
                                                   input int unsigned shamt_w,
                                                   input int unsigned stages_per_reg);
    int unsigned last;
    last = (g + 1) * stages_per_reg;
    if (last > shamt_w) last = shamt_w;
    return last - 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational mux stage of the barrel shifter: shifts by 2**K when en=1.
// Rotate support is only built when SHIFTER_ROR_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] data_out_c
);

  localparam int unsigned    S       = 2 ** K;
  localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> S);

  always_comb begin
    data_out_c = data_in;
    if (en) begin
      case (sh_op_e'(op))
        SH_OP_SLL: data_out_c = data_in << S;
        SH_OP_SRL: data_out_c = data_in >> S;
        SH_OP_SRA: data_out_c = (data_in >> S) | (fill ? HI_MASK : '0);
`ifdef SHIFTER_ROR_EN
        SH_OP_ROR: data_out_c = (data_in >> S) | (data_in << (WIDTH - S));
`endif
        // Unsupported op: value is discarded at the output register.
        default:   data_out_c = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA barrel shifter with valid/ready on both sides.
// Define SHIFTER_ROR_EN to add rotate-right on op 2'b11; otherwise that op is flagged illegal.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned STAGES_PER_REG = 2,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned LAT     = calc_lat(SHAMT_W, STAGES_PER_REG);

  // Group inputs: group 0 is fed from the ports, group g from register g-1.
  logic [WIDTH-1:0]   gi_data  [LAT];
  logic [1:0]         gi_op    [LAT];
  logic               gi_fill  [LAT];
  logic [SHAMT_W-1:0] gi_shamt [LAT];
  logic [TAG_W-1:0]   gi_tag   [LAT];
  logic               gi_valid [LAT];

  logic [WIDTH-1:0]   r_data  [LAT];
  logic [1:0]         r_op    [LAT];
  logic               r_fill  [LAT];
  logic [SHAMT_W-1:0] r_shamt [LAT];
  logic [TAG_W-1:0]   r_tag   [LAT];
  logic               r_valid [LAT];
  logic               r_illegal;

  logic [WIDTH-1:0]   st_in    [SHAMT_W];
  logic [WIDTH-1:0]   st_out   [SHAMT_W];
  logic [WIDTH-1:0]   cap_data [LAT];

  logic advance_c;
  logic illegal_c;
  logic unused_bits;

  // A full output register that is not being drained freezes the whole pipe.
  assign advance_c = out_ready | ~out_valid;
  assign in_ready  = advance_c;

  always_comb begin
    gi_data[0]  = in_x;
    gi_op[0]    = in_op;
    gi_fill[0]  = in_x[WIDTH-1];
    gi_shamt[0] = in_shamt[SHAMT_W-1:0];
    gi_tag[0]   = in_tag;
    gi_valid[0] = in_valid;
    for (int g = 1; g < LAT; g++) begin
      gi_data[g]  = r_data[g-1];
      gi_op[g]    = r_op[g-1];
      gi_fill[g]  = r_fill[g-1];
      gi_shamt[g] = r_shamt[g-1];
      gi_tag[g]   = r_tag[g-1];
      gi_valid[g] = r_valid[g-1];
    end
  end

  // Mux chain; the first stage of each group reads that group's register.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int unsigned G = 32'(k) / STAGES_PER_REG;

    if ((32'(k) % STAGES_PER_REG) == 0) begin : g_head
      assign st_in[k] = gi_data[G];
    end else begin : g_body
      assign st_in[k] = st_out[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .K     (32'(k))
    ) u_stage (
      .data_in    (st_in[k]),
      .op         (gi_op[G]),
      .fill       (gi_fill[G]),
      .en         (gi_shamt[G][k]),
      .data_out_c (st_out[k])
    );
  end

`ifdef SHIFTER_ROR_EN
  assign illegal_c = 1'b0;
`else
  assign illegal_c = (gi_op[LAT-1] == SH_OP_ROR);
`endif

  // Values captured at the end of each group; illegal ops leave a zero result.
  for (genvar g = 0; g < LAT; g++) begin : g_cap
    localparam int unsigned LAST = group_last_stage(32'(g), SHAMT_W, STAGES_PER_REG);
    if (g == LAT - 1) begin : g_final
      assign cap_data[g] = illegal_c ? '0 : st_out[LAST];
    end else begin : g_mid
      assign cap_data[g] = st_out[LAST];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < LAT; g++) begin
        r_data[g]  <= '0;
        r_op[g]    <= '0;
        r_fill[g]  <= 1'b0;
        r_shamt[g] <= '0;
        r_tag[g]   <= '0;
        r_valid[g] <= 1'b0;
      end
      r_illegal <= 1'b0;
    end else if (advance_c) begin
      for (int g = 0; g < LAT; g++) begin
        r_data[g]  <= cap_data[g];
        r_op[g]    <= gi_op[g];
        r_fill[g]  <= gi_fill[g];
        r_shamt[g] <= gi_shamt[g];
        r_tag[g]   <= gi_tag[g];
        r_valid[g] <= gi_valid[g];
      end
      r_illegal <= illegal_c;
    end
  end

  assign out_valid   = r_valid[LAT-1];
  assign out_result  = r_data[LAT-1];
  assign out_tag     = r_tag[LAT-1];
  assign out_illegal = r_illegal;

  // Upper shamt bits and the control copies in the last register are never consumed.
  always_comb begin
    unused_bits = ^in_shamt;
    for (int g = 0; g < LAT; g++) begin
      unused_bits = unused_bits ^ (^r_shamt[g]) ^ (^r_op[g]) ^ r_fill[g];
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomised checks of shift_pipe at WIDTH=32/STAGES_PER_REG=2
// and WIDTH=8/STAGES_PER_REG=1; expectations follow SHIFTER_ROR_EN.
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_x, in_shamt, out_result;
  logic [1:0]  in_op;
  logic [4:0]  in_tag, out_tag;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [7:0]  b_in_x, b_in_shamt, b_out_result;
  logic [1:0]  b_in_op;
  logic [4:0]  b_in_tag, b_out_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .STAGES_PER_REG(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  shift_pipe #(.WIDTH(8), .STAGES_PER_REG(1), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_shamt(b_in_shamt),
    .in_op(b_in_op), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [31:0] sh,
                                            input logic [1:0] op);
    int s;
    logic [31:0] r;
    s = int'(sh[4:0]);
    case (op)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = 32'($signed(x) >>> s);
`ifdef SHIFTER_ROR_EN
      default: r = (x >> s) | (x << (32 - s));
`else
      default: r = 32'h0;
`endif
    endcase
    return r;
  endfunction

  function automatic logic ref_illegal(input logic [1:0] op);
`ifdef SHIFTER_ROR_EN
    return 1'b0;
`else
    return op == 2'b11;
`endif
  endfunction

  // Single transaction on the 32-bit pipe; lat counts edges from accept to out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] sh, input logic [1:0] op,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] tg, output logic ill, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_shamt = sh; in_op = op; in_tag = tag; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = out_result; tg = out_tag; ill = out_illegal;
    if (!out_valid) lat = -1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", out_result); end
    n_vec++; if (out_tag !== 5'h0 || out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_tag_ill: got %h/%b want 0/0", out_tag, out_illegal); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid8: got %b want 0", b_out_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_ops;
    logic [31:0] r; logic [4:0] t; logic il; int lat;
    run_op(32'h0000_0001, 32'd2, SH_OP_SLL, 5'd3, r, t, il, lat);
    n_vec++; if (r !== 32'h0000_0004) begin n_err++; $display("FAIL sll_1_by_2: got %h want 00000004", r); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL latency: got %0d want 3", lat); end
    n_vec++; if (t !== 5'd3 || il !== 1'b0) begin n_err++; $display("FAIL sll_tag_ill: got %h/%b want 03/0", t, il); end
    run_op(32'h8000_0000, 32'd31, SH_OP_SRL, 5'd4, r, t, il, lat);
    n_vec++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL srl_by_31: got %h want 00000001", r); end
    run_op(32'h8000_0000, 32'd31, SH_OP_SRA, 5'd5, r, t, il, lat);
    n_vec++; if (r !== 32'hFFFF_FFFF || t !== 5'd5) begin n_err++; $display("FAIL sra_by_31: got %h/%h want ffffffff/05", r, t); end
    run_op(32'h4000_0000, 32'd4, SH_OP_SRA, 5'd6, r, t, il, lat);
    n_vec++; if (r !== 32'h0400_0000) begin n_err++; $display("FAIL sra_positive: got %h want 04000000", r); end
  endtask

  task automatic test_shamt_mask;
    logic [31:0] r; logic [4:0] t; logic il; int lat;
    run_op(32'hA5A5_A5A5, 32'h30, SH_OP_SLL, 5'd1, r, t, il, lat);
    n_vec++; if (r !== 32'hA5A5_0000) begin n_err++; $display("FAIL sll_shamt_0x30: got %h want a5a50000", r); end
    run_op(32'h8000_0000, 32'd33, SH_OP_SRL, 5'd2, r, t, il, lat);
    n_vec++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL srl_shamt_33: got %h want 40000000", r); end
    for (int op = 0; op < 3; op++) begin
      run_op(32'hFFFF_FFFF, 32'd0, 2'(op), 5'(op), r, t, il, lat);
      n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL zero_shift_op%0d: got %h want ffffffff", op, r); end
    end
  endtask

  task automatic test_op11;
    logic [31:0] r; logic [4:0] t; logic il; int lat;
    run_op(32'h0000_0001, 32'd1, SH_OP_ROR, 5'd11, r, t, il, lat);
`ifdef SHIFTER_ROR_EN
    n_vec++; if (r !== 32'h8000_0000 || il !== 1'b0) begin n_err++; $display("FAIL ror_1_by_1: got %h/%b want 80000000/0", r, il); end
    run_op(32'h1234_5678, 32'd8, SH_OP_ROR, 5'd12, r, t, il, lat);
    n_vec++; if (r !== 32'h7812_3456) begin n_err++; $display("FAIL ror_by_8: got %h want 78123456", r); end
`else
    n_vec++; if (r !== 32'h0 || il !== 1'b1) begin n_err++; $display("FAIL op11_illegal: got %h/%b want 00000000/1", r, il); end
`endif
    n_vec++; if (lat !== 3 || t !== 5'd11) begin n_err++; $display("FAIL op11_lat_tag: got %0d/%h want 3/0b", lat, t); end
  endtask

  task automatic test_back_to_back;
    int issued = 0;
    int got = 0;
    logic [31:0] held = '0;
    logic [4:0]  held_tag = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 8);
      in_valid  = (issued < 6);
      in_x = 32'h1; in_shamt = 32'(issued); in_op = SH_OP_SLL; in_tag = 5'(issued);
      #1;
      if (!out_ready) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
        if (c == 4) begin
          held = out_result; held_tag = out_tag;
          n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", out_valid); end
        end else begin
          n_vec++;
          if (out_result !== held || out_tag !== held_tag) begin
            n_err++; $display("FAIL stall_stable c%0d: got %h/%h want %h/%h", c, out_result, out_tag, held, held_tag);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_result !== (32'h1 << got) || out_tag !== 5'(got)) begin
          n_err++; $display("FAIL b2b_order #%0d: got %h/%h want %h/%h", got, out_result, out_tag, 32'h1 << got, 5'(got));
        end
        got++;
      end
      if (in_valid && in_ready) issued++;
    end
    n_vec++; if (got !== 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", got); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight;
    logic [31:0] r; logic [4:0] t; logic il; int lat;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 32'h1; in_shamt = 32'd1; in_op = SH_OP_SLL; in_tag = 5'd7;
    @(negedge clk);
    in_x = 32'h3; in_tag = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'h2) begin n_err++; $display("FAIL pre_reset_out: got %b/%h want 1/00000002", out_valid, out_result); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin n_err++; $display("FAIL async_reset_out: got %b/%h want 0/00000000", out_valid, out_result); end
    n_vec++; if (out_tag !== 5'h0 || out_illegal !== 1'b0) begin n_err++; $display("FAIL async_reset_tag: got %h/%b want 00/0", out_tag, out_illegal); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL discard_inflight: got %0d emitted want 0", seen); end
    run_op(32'h5555_5555, 32'd1, SH_OP_SLL, 5'd9, r, t, il, lat);
    n_vec++; if (r !== 32'hAAAA_AAAA || t !== 5'd9) begin n_err++; $display("FAIL post_reset_sll: got %h/%h want aaaaaaaa/09", r, t); end
  endtask

  task automatic test_param_sweep;
    logic [7:0] vx[4]  = '{8'h81, 8'h80, 8'h01, 8'hF0};
    logic [7:0] vs[4]  = '{8'd1,  8'd7,  8'd9,  8'd4};
    logic [1:0] vo[4]  = '{2'b10, 2'b10, 2'b00, 2'b01};
    logic [7:0] ve[4]  = '{8'hC0, 8'hFF, 8'h02, 8'h0F};
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_x = vx[i]; b_in_shamt = vs[i]; b_in_op = vo[i];
      b_in_tag = 5'(i + 20); b_out_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      b_in_valid = 1'b0;
      while (!b_out_valid && lat < 20) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      n_vec++;
      if (b_out_result !== ve[i] || b_out_tag !== 5'(i + 20) || lat !== 3) begin
        n_err++; $display("FAIL w8_vec%0d: got %h/%h lat %0d want %h/%h lat 3", i, b_out_result, b_out_tag, lat, ve[i], 5'(i + 20));
      end
      @(posedge clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] q_res[$];
    logic [4:0]  q_tag[$];
    logic        q_ill[$];
    logic [31:0] er; logic [4:0] et; logic ei;
    int sent = 0;
    int cyc = 0;
    while ((sent < 1000 || q_res.size() > 0) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(3) != 0);
      in_valid  = (sent < 1000) && ($urandom_range(4) != 0);
      in_x = $urandom; in_shamt = $urandom; in_op = 2'($urandom_range(3)); in_tag = 5'($urandom);
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (q_res.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious: got %h want no output", out_result);
        end else begin
          er = q_res.pop_front(); et = q_tag.pop_front(); ei = q_ill.pop_front();
          if (out_result !== er || out_tag !== et || out_illegal !== ei) begin
            n_err++; $display("FAIL rnd_result: got %h/%h/%b want %h/%h/%b", out_result, out_tag, out_illegal, er, et, ei);
          end
        end
      end
      if (in_valid && in_ready) begin
        q_res.push_back(ref_shift(in_x, in_shamt, in_op));
        q_tag.push_back(in_tag);
        q_ill.push_back(ref_illegal(in_op));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (sent !== 1000 || q_res.size() !== 0) begin
      n_err++; $display("FAIL rnd_drain: got sent %0d pending %0d want 1000/0", sent, q_res.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic_ops;
    test_shamt_mask;
    test_op11;
    test_back_to_back;
    test_reset_midflight;
    test_param_sweep;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
